// File: rtl/urish_btn_conditioner.sv
// urish_btn_conditioner: synchronise, polarity-correct and debounce NUM_BTN push-buttons into
// clean levels plus one-cycle press/release pulses. Define BTN_LOCKOUT_EN for single-owner reporting.
module urish_btn_conditioner #(
  parameter int NUM_BTN     = 4,
  parameter int CLK_KHZ     = 10_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               btn_active_low,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_held,
  output logic               ms_tick
);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } state_e;

  localparam logic [15:0] PRE_LAST = 16'(CLK_KHZ - 1);
  localparam logic [7:0]  CNT_LAST = 8'(DEBOUNCE_MS - 1);

  // Reset asserts asynchronously but is released two clocks after the pad deasserts.
  logic [1:0] rst_pipe_d, rst_pipe_q;
  logic       rst_n;

  always_comb rst_pipe_d = {rst_pipe_q[0], 1'b1};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rst_pipe_q <= '0;
    else            rst_pipe_q <= rst_pipe_d;
  end

  assign rst_n = rst_pipe_q[1];

  logic [15:0]        pre_d, pre_q;
  logic               tick_d, tick_q;
  logic [NUM_BTN-1:0] sync1_d, sync1_q, sync2_d, sync2_q, samp;

  always_comb begin
    tick_d  = (pre_q == PRE_LAST);
    pre_d   = tick_d ? 16'd0 : pre_q + 16'd1;
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    samp    = sync2_q ^ {NUM_BTN{btn_active_low}};
  end

  state_e             state_d [NUM_BTN];
  state_e             state_q [NUM_BTN];
  logic [7:0]         cnt_d   [NUM_BTN];
  logic [7:0]         cnt_q   [NUM_BTN];
  logic [NUM_BTN-1:0] held_d;

  // Counter is cleared on entry to a pending state and only advances on ms ticks.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_RELEASED: begin
          if (samp[i]) begin
            state_d[i] = ST_PRESS_PEND;
            cnt_d[i]   = 8'd0;
          end
        end
        ST_PRESS_PEND: begin
          if (!samp[i])                   state_d[i] = ST_RELEASED;
          else if (tick_q) begin
            if (cnt_q[i] == CNT_LAST)     state_d[i] = ST_HELD;
            else                          cnt_d[i]   = cnt_q[i] + 8'd1;
          end
        end
        ST_HELD: begin
          if (!samp[i]) begin
            state_d[i] = ST_RELEASE_PEND;
            cnt_d[i]   = 8'd0;
          end
        end
        ST_RELEASE_PEND: begin
          if (samp[i])                    state_d[i] = ST_HELD;
          else if (tick_q) begin
            if (cnt_q[i] == CNT_LAST)     state_d[i] = ST_RELEASED;
            else                          cnt_d[i]   = cnt_q[i] + 8'd1;
          end
        end
        default:                          state_d[i] = ST_RELEASED;
      endcase
      held_d[i] = (state_q[i] == ST_HELD) || (state_q[i] == ST_RELEASE_PEND);
    end
  end

  logic [NUM_BTN-1:0] lvl_d, lvl_q, press_d, press_q, rel_d, rel_q;

`ifdef BTN_LOCKOUT_EN
  logic [NUM_BTN-1:0] held_q, own_d, own_q, rise;

  // A button already held when ownership frees up never sees a new rise, so stays masked.
  always_comb begin
    rise  = held_d & ~held_q;
    own_d = own_q;
    if ((own_q & ~held_d) != '0) begin
      own_d = '0;
    end else if (own_q == '0) begin
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
        if (rise[i]) begin
          own_d    = '0;
          own_d[i] = 1'b1;
        end
      end
    end
    lvl_d = held_d & own_d;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      own_q  <= '0;
    end else begin
      held_q <= held_d;
      own_q  <= own_d;
    end
  end
`else
  always_comb lvl_d = held_d;
`endif

  always_comb begin
    press_d = lvl_d & ~lvl_q;
    rel_d   = ~lvl_d & lvl_q;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= 8'd0;
      end
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level   = lvl_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign any_held    = |lvl_q;
  assign ms_tick     = tick_q;

endmodule

// File: tb/tb_urish_btn_conditioner.sv
// Scoreboard bench for urish_btn_conditioner (CLK_KHZ=10, DEBOUNCE_MS=3: 1 ms = 10 cycles).
// Expectations for the lockout case follow BTN_LOCKOUT_EN when the bench is built with it.
module tb_urish_btn_conditioner;
  localparam int NB  = 4;
  localparam int KHZ = 10;
  localparam int DMS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] raw = '0;
  logic          al = 1'b0;
  logic [NB-1:0] lvl, prs, rel;
  logic          anyh, tick;

  urish_btn_conditioner #(.NUM_BTN(NB), .CLK_KHZ(KHZ), .DEBOUNCE_MS(DMS)) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .btn_raw       (raw),
    .btn_active_low(al),
    .btn_level     (lvl),
    .btn_press     (prs),
    .btn_release   (rel),
    .any_held      (anyh),
    .ms_tick       (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] lvl;
    int            lo;
    int            hi;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Expected event: committed edge lands 30..42 cycles after the raw change issued now.
  task automatic push(input logic [NB-1:0] p, input logic [NB-1:0] r, input logic [NB-1:0] l);
    exp_t e;
    e.prs = p;
    e.rel = r;
    e.lvl = l;
    e.lo  = cyc + 30;
    e.hi  = cyc + 42;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output int c);
    int g;
    g = 0;
    @(negedge clk);
    while (tick !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    n_chk++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_timeout: ms_tick actual %b required 1 within 40 cycles", tick);
    end
    c = cyc;
  endtask

  // Place the next raw change so the FSM enters its pending state on a tick edge (worst phase).
  task automatic align();
    int c;
    wait_tick(c);
    repeat (8) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("press_release_exclusive", 32'(prs & rel), 32'd0);
      check("any_held", 32'(anyh), 32'(|lvl));
      if ((prs | rel) != '0) begin : pop_blk
        exp_t e;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: actual press=%b release=%b level=%b, required no event",
                   prs, rel, lvl);
        end else begin
          e = sb.pop_front();
          check("event_press", 32'(prs), 32'(e.prs));
          check("event_release", 32'(rel), 32'(e.rel));
          check("event_level", 32'(lvl), 32'(e.lvl));
          n_chk++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_fail++;
            $display("FAIL event_latency: actual cycle %0d required %0d..%0d", cyc, e.lo, e.hi);
          end
        end
      end
    end
  end

  initial begin
    int t0, t1;

    cycles(3);
    check("reset_level", 32'(lvl), 32'd0);
    check("reset_press", 32'(prs), 32'd0);
    check("reset_release", 32'(rel), 32'd0);
    check("reset_any_held", 32'(anyh), 32'd0);
    check("reset_ms_tick", 32'(tick), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    wait_tick(t0);
    wait_tick(t1);
    check("tick_period", 32'(t1 - t0), 32'd10);

    // clean press and release on button 0
    align();
    raw[0] = 1'b1;
    push(4'b0001, 4'b0000, 4'b0001);
    cycles(100);
    check("clean_level", 32'(lvl), 32'b0001);
    align();
    raw[0] = 1'b0;
    push(4'b0000, 4'b0001, 4'b0000);
    cycles(60);
    check("clean_release_level", 32'(lvl), 32'd0);

    // bouncing button 1
    for (int k = 0; k < 10; k++) begin
      raw[1] = ~raw[1];
      cycles(4);
    end
    check("bounce_no_commit", 32'(lvl), 32'd0);
    align();
    raw[1] = 1'b1;
    push(4'b0010, 4'b0000, 4'b0010);
    cycles(60);
    check("bounce_level", 32'(lvl), 32'b0010);
    align();
    raw[1] = 1'b0;
    push(4'b0000, 4'b0010, 4'b0000);
    cycles(60);

    // 15-cycle glitch on button 2
    raw[2] = 1'b1;
    cycles(15);
    raw[2] = 1'b0;
    cycles(60);
    check("glitch_level", 32'(lvl), 32'd0);

    // active-low pads
    raw = 4'b1111;
    al  = 1'b1;
    cycles(60);
    check("active_low_idle", 32'(lvl), 32'd0);
    align();
    raw[3] = 1'b0;
    push(4'b1000, 4'b0000, 4'b1000);
    cycles(60);
    check("active_low_level", 32'(lvl), 32'b1000);
    align();
    raw[3] = 1'b1;
    push(4'b0000, 4'b1000, 4'b0000);
    cycles(60);
    raw = 4'b0000;
    al  = 1'b0;
    cycles(60);
    check("active_low_restore", 32'(lvl), 32'd0);

    // simultaneous commit, then reset mid-operation
    align();
    raw = 4'b0011;
    push(4'b0011, 4'b0000, 4'b0011);
    cycles(60);
    check("dual_level", 32'(lvl), 32'b0011);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_level", 32'(lvl), 32'd0);
    check("async_reset_any_held", 32'(anyh), 32'd0);
    check("async_reset_press", 32'(prs), 32'd0);
    check("async_reset_release", 32'(rel), 32'd0);
    cycles(3);
    rst_n = 1'b1;
    push(4'b0011, 4'b0000, 4'b0011);
    cycles(60);
    check("post_reset_level", 32'(lvl), 32'b0011);
    align();
    raw = 4'b0000;
    push(4'b0000, 4'b0011, 4'b0000);
    cycles(60);

    // press 2 then 0; release 2
    align();
    raw[2] = 1'b1;
    push(4'b0100, 4'b0000, 4'b0100);
    cycles(60);
    align();
    raw[0] = 1'b1;
`ifdef BTN_LOCKOUT_EN
    cycles(60);
    check("lockout_level", 32'(lvl), 32'b0100);
    align();
    raw[2] = 1'b0;
    push(4'b0000, 4'b0100, 4'b0000);
    cycles(60);
    check("lockout_masked_after_release", 32'(lvl), 32'd0);
    align();
    raw[0] = 1'b0;
    cycles(60);
    align();
    raw[0] = 1'b1;
    push(4'b0001, 4'b0000, 4'b0001);
    cycles(60);
    check("lockout_new_owner", 32'(lvl), 32'b0001);
`else
    push(4'b0001, 4'b0000, 4'b0101);
    cycles(60);
    check("independent_level", 32'(lvl), 32'b0101);
    align();
    raw[2] = 1'b0;
    push(4'b0000, 4'b0100, 4'b0001);
    cycles(60);
    check("independent_after_release", 32'(lvl), 32'b0001);
`endif
    align();
    raw[0] = 1'b0;
    push(4'b0000, 4'b0001, 4'b0000);
    cycles(60);
    check("final_level", 32'(lvl), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
